// File: rtl/pipelined_group_subtractor.sv
// Group-pipelined ripple-borrow subtractor: one GROUP_SIZE-bit group per stage, valid/ready flow control.
// Define SUB_OVERFLOW_EN to add the pipelined two's-complement overflow output Ovf.
module pipelined_group_subtractor #(
  parameter int unsigned N          = 16,
  parameter int unsigned GROUP_SIZE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] Diff,
  output logic         Bout,
  output logic         out_valid,
  input  logic         out_ready
`ifdef SUB_OVERFLOW_EN
  ,
  output logic         Ovf
`endif
);

  localparam int unsigned GS     = GROUP_SIZE;
  localparam int unsigned GROUPS = N / GROUP_SIZE;

  // Whole pipeline moves as one; a stalled output freezes every stage.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar g = 0; g < GROUPS; g++) begin : g_stage
    // Stage g sees only the operand bits from its own group upward.
    localparam int unsigned IW = N - g * GS;
    localparam int unsigned DW = (g + 1) * GS;

    logic [IW-1:0] a_in;
    logic [IW-1:0] b_in;
    logic          br_in;
    logic          v_in;
    logic [GS:0]   bc;
    logic [GS-1:0] dg;
    logic [DW-1:0] d_d;
    logic [DW-1:0] d_q;
    logic          br_q;
    logic          v_q;

    if (g == 0) begin : g_src
      assign a_in  = A;
      assign b_in  = B;
      assign br_in = Bin;
      assign v_in  = in_valid;
      assign d_d   = dg;
    end else begin : g_src
      assign a_in  = g_stage[g-1].g_fwd.a_q;
      assign b_in  = g_stage[g-1].g_fwd.b_q;
      assign br_in = g_stage[g-1].br_q;
      assign v_in  = g_stage[g-1].v_q;
      assign d_d   = {dg, g_stage[g-1].d_q};
    end

    assign bc[0] = br_in;
    for (genvar i = 0; i < GS; i++) begin : g_bit
      assign dg[i]   = a_in[i] ^ b_in[i] ^ bc[i];
      assign bc[i+1] = (~a_in[i] & b_in[i]) | (~(a_in[i] ^ b_in[i]) & bc[i]);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q  <= 1'b0;
        br_q <= 1'b0;
        d_q  <= '0;
      end else if (advance) begin
        v_q  <= v_in;
        br_q <= bc[GS];
        d_q  <= d_d;
      end
    end

    if (g < GROUPS - 1) begin : g_fwd
      localparam int unsigned UW = IW - GS;
      logic [UW-1:0] a_q;
      logic [UW-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_in[IW-1:GS];
          b_q <= b_in[IW-1:GS];
        end
      end
    end
  end

  assign out_valid = g_stage[GROUPS-1].v_q;
  assign Diff      = g_stage[GROUPS-1].d_q;
  assign Bout      = g_stage[GROUPS-1].br_q;

`ifdef SUB_OVERFLOW_EN
  // Overflow is decided in the top stage, where the sign bits are still on hand.
  logic ovf_d;
  logic ovf_q;

  assign ovf_d = (g_stage[GROUPS-1].a_in[GS-1] != g_stage[GROUPS-1].b_in[GS-1]) &&
                 (g_stage[GROUPS-1].dg[GS-1]   != g_stage[GROUPS-1].a_in[GS-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_d;
    end
  end

  assign Ovf = ovf_q;
`endif

endmodule
